bytes_to_bridge: RTL and testbench
==================================

# bytes_to_bridge

Read-side counterpart of the byte-wide ROM loader: serves 32-bit APF bridge read requests from an 8-bit, fixed-latency memory port. Each request is split into four sequential byte reads, and the bytes are packed into one bridge word. It lives in the core clock domain, behind the bridge CDC. The core uses it to read back loaded ROM or RAM contents, for example for save data or debug.

## Interface
Parameters:
- ADDR_WIDTH, 25, byte address width of the memory port
- READ_LATENCY, 2, cycles from an accepted mem_rd to valid mem_rd_data; legal range 1..15
- BIG_ENDIAN, 1, 1: lowest byte address lands in bits 31:24; 0: lowest byte lands in bits 7:0

Ports:
- clk, input, 1, core clock; the block has one clock
- reset, input, 1, asynchronous active-high reset
- br_addr, input, 32, bridge byte address; sampled only when br_rd is accepted
- br_rd, input, 1, read request; single-cycle pulse
- br_rd_data, output, 32, assembled word; held until the next completion
- br_rd_valid, output, 1, one-cycle pulse; br_rd_data is valid in this cycle
- br_busy, output, 1, high while a request is in flight
- mem_addr, output, ADDR_WIDTH, byte address presented to memory
- mem_rd, output, 1, byte read strobe
- mem_wait, input, 1, memory stall; a mem_rd asserted while mem_wait is high is not accepted
- mem_rd_data, input, 8, read data; valid READ_LATENCY cycles after the accepted strobe

## Operation
- States:
  - IDLE: br_busy=0. On br_rd: latch br_addr, clear byte_idx, go to ISSUE.
  - ISSUE: drive mem_rd=1 and mem_addr={br_addr[ADDR_WIDTH-1:2], byte_idx}.
    - If mem_wait=1: stay in ISSUE; mem_rd and mem_addr are held unchanged.
    - If mem_wait=0: load the latency counter with READ_LATENCY and go to WAIT.
  - WAIT: mem_rd=0. Count down. In the final WAIT cycle (counter==1), capture mem_rd_data into the byte lane for byte_idx.
    - If byte_idx==3: go to DONE.
    - Otherwise: increment byte_idx and go to ISSUE.
  - DONE: pulse br_rd_valid for exactly one cycle, with br_rd_data updated. Return to IDLE.
- Address handling: br_addr[1:0] and br_addr[31:ADDR_WIDTH] are ignored. All reads are word-aligned, in byte order 0, 1, 2, 3.
- Byte packing: BIG_ENDIAN=1 gives {b0,b1,b2,b3}; BIG_ENDIAN=0 gives {b3,b2,b1,b0}.
- Assembly uses a separate shift/assembly register. br_rd_data is loaded atomically on entry to DONE, so it never shows a partially assembled word.
- br_rd while br_busy=1 (including the DONE cycle) is dropped silently: no queueing and no error.
- Reset (any state): go to IDLE; mem_rd=0, br_rd_valid=0, br_busy=0, br_rd_data=0, mem_addr=0, byte_idx=0. A read in flight is abandoned with no valid pulse.

## Timing
- br_rd is sampled at edge N. First mem_rd is high in cycle N+1.
- Byte k strobe is in cycle N+1+k(READ_LATENCY+1), plus any stall cycles.
- Without stalls, br_rd_valid is high in cycle N+4·READ_LATENCY+5. With READ_LATENCY=2 this is N+13.
- Each mem_wait cycle during ISSUE adds exactly one cycle to the total latency.
- br_busy:
  - Rises in cycle N+1.
  - Is high in the DONE cycle and falls in the cycle after it.
  - The next br_rd is accepted at the earliest one cycle after br_rd_valid.
- All outputs are registered.
- mem_rd_data is sampled only in the capture cycle. Its value at any other time is don't-care.

## Structure
- The shared core package holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE) as bytes_to_bridge_state_t;
  - a constant for the default ROM read latency.
- The latency counter is 4 bits wide, inline; no sub-module is needed.

## Test plan
- Memory model with latency 2 and bytes 0x11,0x22,0x33,0x44 at 0x100..0x103. Read of br_addr=0x0000_0102:
  - mem_addr sequence 0x100,0x101,0x102,0x103;
  - br_rd_valid 13 cycles after br_rd, with br_rd_data=0x11223344.
- Same read with BIG_ENDIAN=0: br_rd_data=0x44332211.
- mem_wait held high 3 cycles on byte 1:
  - mem_rd and mem_addr=0x101 stable throughout the stall;
  - valid at N+16;
  - data correct.
- Second br_rd issued mid-transfer and in the DONE cycle: both dropped; exactly one br_rd_valid; the following br_rd is served normally.
- Reset asserted during WAIT of byte 2:
  - outputs are 0 immediately (asynchronous);
  - no valid pulse;
  - the next read after deassertion returns the correct word.
- READ_LATENCY=1 and READ_LATENCY=15 builds: latency is 9 and 65 cycles respectively; data correct.

Source files
------------

// File: rtl/bytes_to_bridge_pkg.sv
// Shared types and constants for the byte-port to APF bridge read engine.
package bytes_to_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } bytes_to_bridge_state_t;

    // Read latency of the ROM/RAM port the loader normally sits on.
    localparam int DEFAULT_ROM_READ_LATENCY = 2;

endpackage

// File: rtl/bytes_to_bridge.sv
// Serves 32-bit bridge reads by issuing four sequential byte reads to a
// fixed-latency 8-bit memory port and packing the bytes into one word.
module bytes_to_bridge
    import bytes_to_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH   = 25,
    parameter int READ_LATENCY = DEFAULT_ROM_READ_LATENCY,
    parameter bit BIG_ENDIAN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           br_addr,
    input  logic                  br_rd,
    output logic [31:0]           br_rd_data,
    output logic                  br_rd_valid,
    output logic                  br_busy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic                  mem_wait,
    input  logic [7:0]            mem_rd_data
);

    localparam logic [3:0] LAT_LOAD = 4'(READ_LATENCY);

    bytes_to_bridge_state_t state_q;
    logic [ADDR_WIDTH-3:0]  word_addr_q;
    logic [1:0]             byte_idx_q;
    logic [3:0]             lat_cnt_q;
    logic [31:0]            asm_q;
    logic [31:0]            asm_d;
    logic [31:0]            br_rd_data_q;
    logic                   br_rd_valid_q;
    logic                   br_busy_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic                   mem_rd_q;
    logic [1:0]             lane;
    logic                   unused_addr_bits;

    // Word-aligned reads only; offset and high address bits are don't-care.
    assign unused_addr_bits = ^{br_addr[31:ADDR_WIDTH], br_addr[1:0]};

    // Big-endian puts byte 0 in the top lane, so the lane index is inverted.
    assign lane = BIG_ENDIAN ? ~byte_idx_q : byte_idx_q;

    always_comb begin
        // NOTE: default assignment first, so every path drives asm_d and no latch is inferred.
        asm_d = asm_q;
        case (lane)
            2'd0:    asm_d[7:0]   = mem_rd_data;
            2'd1:    asm_d[15:8]  = mem_rd_data;
            2'd2:    asm_d[23:16] = mem_rd_data;
            default: asm_d[31:24] = mem_rd_data;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every register including the assembly word is reset, so an abandoned read leaves no trace.
            state_q       <= IDLE;
            word_addr_q   <= '0;
            byte_idx_q    <= 2'd0;
            lat_cnt_q     <= 4'd0;
            asm_q         <= 32'd0;
            br_rd_data_q  <= 32'd0;
            br_rd_valid_q <= 1'b0;
            br_busy_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_rd_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
            br_rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (br_rd) begin
                        word_addr_q <= br_addr[ADDR_WIDTH-1:2];
                        byte_idx_q  <= 2'd0;
                        mem_addr_q  <= {br_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_rd_q    <= 1'b1;
                        br_busy_q   <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A stalled strobe keeps mem_rd and mem_addr exactly as they are.
                    if (!mem_wait) begin
                        mem_rd_q  <= 1'b0;
                        lat_cnt_q <= LAT_LOAD;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt_q == 4'd1) begin
                        asm_q <= asm_d;
                        if (byte_idx_q == 2'd3) begin
                            br_rd_data_q  <= asm_d;
                            br_rd_valid_q <= 1'b1;
                            state_q       <= DONE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            mem_addr_q <= {word_addr_q, byte_idx_q + 2'd1};
                            mem_rd_q   <= 1'b1;
                            state_q    <= ISSUE;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    br_busy_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign br_rd_data  = br_rd_data_q;
    assign br_rd_valid = br_rd_valid_q;
    assign br_busy     = br_busy_q;
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;

endmodule

// File: tb/tb_bytes_to_bridge.sv
// Directed bench for bytes_to_bridge: four builds (BE/L2, LE/L2, BE/L1, BE/L15)
// each behind its own fixed-latency byte memory model.
module tb_bytes_to_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] br_addr;
    logic        mem_wait;
    logic        br_rd  [4];
    logic [31:0] rdata  [4];
    logic        valid  [4];
    logic        busy   [4];
    logic        mrd    [4];
    logic        mwait  [4];
    logic [24:0] maddr  [4];
    logic [7:0]  mrdata [4];
    logic [24:0] pa     [4][15];
    logic        pv     [4][15];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    bytes_to_bridge #(.ADDR_WIDTH(25), .READ_LATENCY(2), .BIG_ENDIAN(1'b1)) u_be_l2 (
        .clk(clk), .reset(reset), .br_addr(br_addr), .br_rd(br_rd[0]),
        .br_rd_data(rdata[0]), .br_rd_valid(valid[0]), .br_busy(busy[0]),
        .mem_addr(maddr[0]), .mem_rd(mrd[0]), .mem_wait(mwait[0]), .mem_rd_data(mrdata[0]));

    bytes_to_bridge #(.ADDR_WIDTH(25), .READ_LATENCY(2), .BIG_ENDIAN(1'b0)) u_le_l2 (
        .clk(clk), .reset(reset), .br_addr(br_addr), .br_rd(br_rd[1]),
        .br_rd_data(rdata[1]), .br_rd_valid(valid[1]), .br_busy(busy[1]),
        .mem_addr(maddr[1]), .mem_rd(mrd[1]), .mem_wait(mwait[1]), .mem_rd_data(mrdata[1]));

    bytes_to_bridge #(.ADDR_WIDTH(25), .READ_LATENCY(1), .BIG_ENDIAN(1'b1)) u_be_l1 (
        .clk(clk), .reset(reset), .br_addr(br_addr), .br_rd(br_rd[2]),
        .br_rd_data(rdata[2]), .br_rd_valid(valid[2]), .br_busy(busy[2]),
        .mem_addr(maddr[2]), .mem_rd(mrd[2]), .mem_wait(mwait[2]), .mem_rd_data(mrdata[2]));

    bytes_to_bridge #(.ADDR_WIDTH(25), .READ_LATENCY(15), .BIG_ENDIAN(1'b1)) u_be_l15 (
        .clk(clk), .reset(reset), .br_addr(br_addr), .br_rd(br_rd[3]),
        .br_rd_data(rdata[3]), .br_rd_valid(valid[3]), .br_busy(busy[3]),
        .mem_addr(maddr[3]), .mem_rd(mrd[3]), .mem_wait(mwait[3]), .mem_rd_data(mrdata[3]));

    function automatic logic [7:0] mem_byte(input logic [24:0] a);
        case (a)
            25'h100: return 8'h11;
            25'h101: return 8'h22;
            25'h102: return 8'h33;
            25'h103: return 8'h44;
            25'h200: return 8'hA1;
            25'h201: return 8'hB2;
            25'h202: return 8'hC3;
            25'h203: return 8'hD4;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        case (i)
            2:       return 1;
            3:       return 15;
            default: return 2;
        endcase
    endfunction

    // Only instance 0 sees the stall input.
    always_comb begin
        mwait[0] = mem_wait;
        mwait[1] = 1'b0;
        mwait[2] = 1'b0;
        mwait[3] = 1'b0;
    end

    // Accepted strobes enter a delay line; data shows READ_LATENCY cycles later, 0xEE otherwise.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            for (int k = 14; k > 0; k--) begin
                pa[i][k] <= pa[i][k-1];
                pv[i][k] <= reset ? 1'b0 : pv[i][k-1];
            end
            pa[i][0] <= maddr[i];
            pv[i][0] <= !reset && mrd[i] && !mwait[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mrdata[i] = pv[i][lat_of(i)-1] ? mem_byte(pa[i][lat_of(i)-1]) : 8'hEE;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bridge read on instance idx, starting at a falling edge. Options: stall a
    // byte for stall_len cycles, inject dropped requests, or reset at cycle reset_cyc.
    task automatic run_read(input int idx, input logic [31:0] addr, input logic [31:0] exp_data,
                            input int exp_lat, input string tag, input int stall_byte,
                            input int stall_len, input int drop_cyc, input bit drop_done,
                            input int reset_cyc);
        logic [24:0] base;
        int          n_acc;
        int          stall_left;
        int          extra;
        bit          got;
        bit          aborted;
        bit          w;
        base       = {addr[24:2], 2'b00};
        n_acc      = 0;
        stall_left = stall_len;
        extra      = 0;
        got        = 1'b0;
        aborted    = 1'b0;
        br_addr    = addr;
        br_rd[idx] = 1'b1;
        for (int c = 1; c <= 200 && !got && !aborted; c++) begin
            @(negedge clk);
            if (c == 1) begin
                br_rd[idx] = 1'b0;
                check({tag, " busy_rise"}, 32'(busy[idx]), 32'd1);
                check({tag, " first_strobe"}, 32'(mrd[idx]), 32'd1);
            end
            if (c == drop_cyc) begin
                br_addr    = 32'h0000_0200;
                br_rd[idx] = 1'b1;
            end
            if (c == drop_cyc + 1) br_rd[idx] = 1'b0;
            mem_wait = 1'b0;
            if (idx == 0 && stall_left > 0 && mrd[idx] && int'(maddr[idx][1:0]) == stall_byte) begin
                check({tag, " stall_addr"}, 32'(maddr[idx]), 32'(base) + 32'(stall_byte));
                mem_wait = 1'b1;
                stall_left--;
            end
            w = (idx == 0) && mem_wait;
            if (mrd[idx] && !w) begin
                check({tag, " mem_addr"}, 32'(maddr[idx]), 32'(base) + 32'(n_acc));
                n_acc++;
            end
            if (c == reset_cyc) begin
                check({tag, " pre_reset_addr"}, 32'(maddr[idx]), 32'(base) + 32'd2);
                check({tag, " pre_reset_mem_rd"}, 32'(mrd[idx]), 32'd0);
                reset = 1'b1;
                #1;
                check({tag, " rst_busy"}, 32'(busy[idx]), 32'd0);
                check({tag, " rst_valid"}, 32'(valid[idx]), 32'd0);
                check({tag, " rst_data"}, rdata[idx], 32'd0);
                check({tag, " rst_mem_addr"}, 32'(maddr[idx]), 32'd0);
                check({tag, " rst_mem_rd"}, 32'(mrd[idx]), 32'd0);
                aborted = 1'b1;
            end
            if (!aborted && valid[idx]) begin
                got = 1'b1;
                check({tag, " latency"}, 32'(c), 32'(exp_lat));
                check({tag, " data"}, rdata[idx], exp_data);
                check({tag, " busy_in_done"}, 32'(busy[idx]), 32'd1);
                check({tag, " strobes"}, 32'(n_acc), 32'd4);
                if (drop_done) begin
                    br_addr    = 32'h0000_0200;
                    br_rd[idx] = 1'b1;
                end
            end
        end
        if (aborted) begin
            repeat (2) @(negedge clk);
            reset = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (valid[idx] || busy[idx]) extra++;
            end
            check({tag, " quiet_after_reset"}, 32'(extra), 32'd0);
        end else begin
            check({tag, " completed"}, 32'(got), 32'd1);
            if (stall_len > 0) check({tag, " stall_consumed"}, 32'(stall_left), 32'd0);
            @(negedge clk);
            br_rd[idx] = 1'b0;
            check({tag, " valid_one_cycle"}, 32'(valid[idx]), 32'd0);
            check({tag, " busy_fall"}, 32'(busy[idx]), 32'd0);
            if (drop_cyc > 0 || drop_done) begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (valid[idx] || busy[idx]) extra++;
                end
                check({tag, " drops_ignored"}, 32'(extra), 32'd0);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        mem_wait = 1'b0;
        br_addr  = 32'd0;
        for (int i = 0; i < 4; i++) br_rd[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("reset_data", rdata[i], 32'd0);
            check("reset_busy", 32'(busy[i]), 32'd0);
            check("reset_mem_rd", 32'(mrd[i]), 32'd0);
            check("reset_mem_addr", 32'(maddr[i]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        run_read(0, 32'h0000_0102, 32'h1122_3344, 13, "be_l2",       -1, 0, -1, 1'b0, -1);
        run_read(1, 32'h0000_0102, 32'h4433_2211, 13, "le_l2",       -1, 0, -1, 1'b0, -1);
        run_read(1, 32'h0000_0043, 32'h1918_1B1A, 13, "le_l2_dflt",  -1, 0, -1, 1'b0, -1);
        run_read(0, 32'h0000_0100, 32'h1122_3344, 16, "stall",        1, 3, -1, 1'b0, -1);
        run_read(0, 32'hFE00_0040, 32'h1A1B_1819, 13, "drop",        -1, 0,  5, 1'b1, -1);
        run_read(0, 32'h0000_0203, 32'hA1B2_C3D4, 13, "after_drop",  -1, 0, -1, 1'b0, -1);
        run_read(0, 32'h0000_0100, 32'h0000_0000,  0, "reset",       -1, 0, -1, 1'b0,  8);
        run_read(0, 32'h0000_0201, 32'hA1B2_C3D4, 13, "after_reset", -1, 0, -1, 1'b0, -1);
        run_read(2, 32'h0000_0100, 32'h1122_3344,  9, "l1",          -1, 0, -1, 1'b0, -1);
        run_read(3, 32'h0000_0200, 32'hA1B2_C3D4, 65, "l15",         -1, 0, -1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
